alarm_siren_driver: RTL and testbench

- Output-side counterpart of the sensor input filter in the alarm controller.
- The filter turns a noisy sensor line into a clean trigger level; this block turns a clean trigger into a timed siren cadence.
- Handles arm/disarm and acknowledge, and enforces a bounded alarm duration.
- Sits between the filtered-sensor logic and the physical siren/buzzer pin.

---
 rtl/alarm_siren_driver.sv | 126 ++++++++++++
 tb/tb_alarm_siren_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_siren_driver.sv
// alarm_siren_driver: turns a clean (filtered) trigger level into a timed siren
// cadence with arm/disarm, acknowledge and bounded alarm duration.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_N        asynchronous reset, active-low
//   arm          level, 1 = armed
//   trigger      clean sensor level; only a rising edge starts an alarm
//   ack          single-cycle silence request
//   siren        registered siren drive
//   alarm_active registered, 1 while sounding (on or off phase)
//   expired      registered, 1 after the bounded alarm duration ran out
module alarm_siren_driver #(
  parameter int unsigned ON_TICKS   = 4,
  parameter int unsigned OFF_TICKS  = 2,
  parameter int unsigned MAX_CYCLES = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic arm,
  input  logic trigger,
  input  logic ack,
  output logic siren,
  output logic alarm_active,
  output logic expired
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] MAX_CYC  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    DISARMED  = 3'd0,
    ARMED     = 3'd1,
    SOUND_ON  = 3'd2,
    SOUND_OFF = 3'd3,
    EXPIRED   = 3'd4
  } state_e;

  state_e           state, state_nx;
  logic [CNT_W-1:0] tick_cnt, tick_nx;
  logic [CNT_W-1:0] cyc_cnt, cyc_nx;
  logic [CNT_W-1:0] cyc_inc_c;
  logic             trig_d;
  logic             trig_edge_c;

  assign trig_edge_c = trigger & ~trig_d;
  // Completed-period count saturates so unlimited mode never wraps.
  assign cyc_inc_c   = (cyc_cnt == CNT_SAT) ? cyc_cnt : CNT_W'(cyc_cnt + 1'b1);

  // State, counters, edge history and outputs decoded from the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= DISARMED;
      tick_cnt     <= '0;
      cyc_cnt      <= '0;
      trig_d       <= 1'b0;
      siren        <= 1'b0;
      alarm_active <= 1'b0;
      expired      <= 1'b0;
    end else begin
      state        <= state_nx;
      tick_cnt     <= tick_nx;
      cyc_cnt      <= cyc_nx;
      trig_d       <= trigger;
      siren        <= (state_nx == SOUND_ON);
      alarm_active <= (state_nx == SOUND_ON) || (state_nx == SOUND_OFF);
      expired      <= (state_nx == EXPIRED);
    end
  end

  // Next-state logic; priority is disarm, ack, timer, trigger edge.
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    cyc_nx   = cyc_cnt;
    unique case (state)
      DISARMED: begin
        if (arm) state_nx = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_nx = DISARMED;
        end else if (trig_edge_c) begin
          state_nx = SOUND_ON;
          tick_nx  = '0;
          cyc_nx   = '0;
        end
      end
      SOUND_ON: begin
        if (!arm) begin
          state_nx = DISARMED;
        end else if (ack) begin
          state_nx = ARMED;
        end else if (tick_cnt == ON_LAST) begin
          state_nx = SOUND_OFF;
          tick_nx  = '0;
        end else begin
          tick_nx = CNT_W'(tick_cnt + 1'b1);
        end
      end
      SOUND_OFF: begin
        if (!arm) begin
          state_nx = DISARMED;
        end else if (ack) begin
          state_nx = ARMED;
        end else if (tick_cnt == OFF_LAST) begin
          cyc_nx  = cyc_inc_c;
          tick_nx = '0;
          if ((MAX_CYC != '0) && (cyc_inc_c == MAX_CYC)) state_nx = EXPIRED;
          else                                           state_nx = SOUND_ON;
        end else begin
          tick_nx = CNT_W'(tick_cnt + 1'b1);
        end
      end
      EXPIRED: begin
        if (!arm)     state_nx = DISARMED;
        else if (ack) state_nx = ARMED;
      end
      default: state_nx = DISARMED;
    endcase
  end

endmodule

// File: tb/tb_alarm_siren_driver.sv
// Self-checking bench: two instances (default 4/2/3 and unlimited 1/1/0) share
// stimulus and are compared every cycle against an elapsed-time model.
module tb_alarm_siren_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic arm = 1'b0;
  logic trigger = 1'b0;
  logic ack = 1'b0;
  logic siren_d, active_d, expired_d;
  logic siren_u, active_u, expired_u;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alarm_siren_driver dut (
    .CLK(clk), .RST_N(rst_n), .arm(arm), .trigger(trigger), .ack(ack),
    .siren(siren_d), .alarm_active(active_d), .expired(expired_d)
  );

  alarm_siren_driver #(.ON_TICKS(1), .OFF_TICKS(1), .MAX_CYCLES(0), .CNT_W(16)) dut_u (
    .CLK(clk), .RST_N(rst_n), .arm(arm), .trigger(trigger), .ack(ack),
    .siren(siren_u), .alarm_active(active_u), .expired(expired_u)
  );

  // Model: mode 0=disarmed 1=armed 2=sounding 3=expired; elapsed = cycles since alarm start.
  int on_t [2] = '{4, 1};
  int off_t[2] = '{2, 1};
  int max_c[2] = '{3, 0};
  int mode   [2] = '{0, 0};
  int elapsed[2] = '{0, 0};
  bit prev   [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    bit rise;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mode[k] = 0; elapsed[k] = 0; prev[k] = 0;
      end else begin
        rise = trigger && !prev[k];
        prev[k] = trigger;
        case (mode[k])
          0: if (arm) mode[k] = 1;
          1: if (!arm) mode[k] = 0;
             else if (rise) begin mode[k] = 2; elapsed[k] = 0; end
          2: if (!arm) mode[k] = 0;
             else if (ack) mode[k] = 1;
             else begin
               elapsed[k]++;
               if (max_c[k] != 0 && elapsed[k] == max_c[k] * (on_t[k] + off_t[k]))
                 mode[k] = 3;
             end
          default: if (!arm) mode[k] = 0; else if (ack) mode[k] = 1;
        endcase
      end
    end
  end

  function automatic bit m_siren(int k);
    return mode[k] == 2 && (elapsed[k] % (on_t[k] + off_t[k])) < on_t[k];
  endfunction

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Continuous compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_siren_d",   siren_d,   m_siren(0));
      check("model_active_d",  active_d,  mode[0] == 2);
      check("model_expired_d", expired_d, mode[0] == 3);
      check("model_siren_u",   siren_u,   m_siren(1));
      check("model_active_u",  active_u,  mode[1] == 2);
      check("model_expired_u", expired_u, mode[1] == 3);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    // Reset held with arm high and trigger toggling.
    for (int i = 0; i < 6; i++) begin
      trigger = ~trigger;
      @(negedge clk);
      check("rst_siren", siren_d, 1'b0);
      check("rst_active", active_d, 1'b0);
      check("rst_expired", expired_d, 1'b0);
    end
    trigger = 1'b0;
    rst_n = 1'b1;
    tick(3);

    // Full cadence with literal expectations.
    trigger = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("cad_siren", siren_d, (i % 6) < 4);
      check("cad_active", active_d, 1'b1);
    end
    @(negedge clk);
    check("cad_expired", expired_d, 1'b1);
    check("cad_active_off", active_d, 1'b0);
    tick(5);
    check("exp_hold", expired_d, 1'b1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("exp_ack", expired_d, 1'b0);

    // Silence with trigger held high, then re-trigger.
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    tick(2);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_siren", siren_d, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("ack_no_retrig", siren_d, 1'b0);
    end
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("retrig_siren", siren_d, i < 4);
    end

    // Disarm and ack together during the off phase.
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    tick(5);
    check("off_phase", siren_d, 1'b0);
    check("off_phase_active", active_d, 1'b1);
    arm = 1'b0; ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("disarm_siren", siren_d, 1'b0);
    check("disarm_active", active_d, 1'b0);
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("disarm_no_alarm", siren_d, 1'b0);
    end

    // Arm while trigger already high: no alarm.
    arm = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("arm_high_trig", active_d, 1'b0);
    end

    // Unlimited mode toggles every cycle.
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check("unl_siren", siren_u, (i % 2) == 0);
      check("unl_expired", expired_u, 1'b0);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("unl_ack", active_u, 1'b0);

    // Asynchronous reset mid-alarm.
    trigger = 1'b0;
    tick(1);
    trigger = 1'b1;
    tick(2);
    check("pre_rst_siren", siren_d, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    arm = 1'b0;
    #1;
    check("async_siren_d", siren_d, 1'b0);
    check("async_siren_u", siren_u, 1'b0);
    check("async_active", active_d, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    trigger = 1'b0;
    tick(2);
    trigger = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", active_d, 1'b0);
    end

    // Randomized phase against the model.
    arm = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      arm = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) trigger = ~trigger;
      ack = ($urandom_range(0, 99) < 2);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
